// File: rtl/button_event_decoder.sv
// Gesture classifier for a clean, debounced button level: emits one-cycle
// press/release pulses plus short-press, long-press and double-click events.
module button_event_decoder #(
    parameter int LONG_PRESS_CYCLES   = 1000,
    parameter int DOUBLE_CLICK_WINDOW = 500,
    parameter int CNT_WIDTH           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic debounced_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT2,
        PRESS2
    } state_t;

    // Compare against N-1: the edge at which cnt would become N is the one that acts.
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WIN_LAST  = CNT_WIDTH'(DOUBLE_CLICK_WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 prev_in;
    logic                 rise;
    logic                 fall;
    logic                 short_next;
    logic                 long_next;
    logic                 double_next;

    assign rise    = debounced_in & ~prev_in;
    assign fall    = ~debounced_in & prev_in;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt_inc;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rise) begin
                    state_next = PRESSED;
                end
            end

            // Reaching the long threshold wins over a fall sampled on the same edge.
            PRESSED: begin
                if (cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = LONG_HELD;
                end else if (fall) begin
                    state_next = WAIT2;
                end
            end

            // Level-based exit so a fall already consumed by PRESSED is still honoured.
            LONG_HELD: begin
                cnt_next = '0;
                if (rise) begin
                    state_next = PRESSED;
                end else if (!debounced_in) begin
                    state_next = IDLE;
                end
            end

            WAIT2: begin
                if (cnt == WIN_LAST) begin
                    short_next = 1'b1;
                    state_next = rise ? PRESSED : IDLE;
                end else if (rise) begin
                    state_next = PRESS2;
                end
            end

            PRESS2: begin
                if (cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = LONG_HELD;
                end else if (fall) begin
                    double_next = 1'b1;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            prev_in       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            prev_in       <= debounced_in;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_press   <= short_next;
            long_press    <= long_next;
            double_click  <= double_next;
            busy          <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: expected pulses are queued with the
// cycle they must appear in, and every cycle the full pulse vector is compared.
module tb_button_event_decoder;

    localparam int L = 20;
    localparam int W = 10;

    localparam logic [4:0] PRESS   = 5'b10000;
    localparam logic [4:0] RELEASE = 5'b01000;
    localparam logic [4:0] SHORT   = 5'b00100;
    localparam logic [4:0] LONG    = 5'b00010;
    localparam logic [4:0] DOUBLE  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    logic debounced_in;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    typedef struct {
        int         at;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic last_in = 1'b0;

    button_event_decoder #(
        .LONG_PRESS_CYCLES  (L),
        .DOUBLE_CLICK_WINDOW(W),
        .CNT_WIDTH          (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .debounced_in (debounced_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic [4:0] v);
        exp_t e;
        e.at = at;
        e.v  = v;
        sb.push_back(e);
    endtask

    task automatic pop_expected(input int c, output logic [4:0] v);
        v = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == c) begin
                v |= sb[i].v;
                sb.delete(i);
            end
        end
    endtask

    // Called just after a negedge; the following posedge samples the new level.
    task automatic set_in(input logic v);
        if (v && !last_in) push(cyc + 1, PRESS);
        if (!v && last_in) push(cyc + 1, RELEASE);
        last_in      = v;
        debounced_in = v;
    endtask

    task automatic tick(output logic [4:0] obs, output logic [4:0] exp);
        @(negedge clk);
        obs = {press_pulse, release_pulse, short_press, long_press, double_click};
        pop_expected(cyc, exp);
    endtask

    task automatic test_reset();
        logic [4:0] o, e;
        rst_n        = 1'b0;
        debounced_in = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            debounced_in = i[0];
            tick(o, e);
            compared++;
            if ({o, busy} !== 6'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=000000", cyc, {o, busy});
            end
        end
        debounced_in = 1'b0;
        last_in      = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(o, e);
            compared++;
            if ({o, busy} !== {e, 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL reset_quiet cyc=%0d got=%b exp=%b", cyc, {o, busy}, {e, 1'b0});
            end
        end
    endtask

    task automatic test_short_press();
        logic [4:0] o, e;
        int lens[2] = '{5, 25};
        for (int s = 0; s < 2; s++) begin
            set_in(s == 0);
            if (s == 1) push(cyc + 1 + W, SHORT);
            for (int i = 0; i < lens[s]; i++) begin
                tick(o, e);
                compared++;
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL short_press cyc=%0d got=%b exp=%b", cyc, o, e);
                end
            end
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL short_busy_end got=%b exp=0", busy);
        end
    endtask

    task automatic test_long_press();
        logic [4:0] o, e;
        int lens[4] = '{40, 10, 20, 10};
        int rise_at = 0;
        for (int s = 0; s < 4; s++) begin
            set_in(s == 0 || s == 2);
            if (s == 0 || s == 2) begin
                rise_at = cyc + 1;
                push(rise_at + L, LONG);
            end
            for (int i = 0; i < lens[s]; i++) begin
                tick(o, e);
                compared++;
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL long_press seg=%0d cyc=%0d got=%b exp=%b", s, cyc, o, e);
                end
                if (s == 0 && i == lens[s] - 1) begin
                    compared++;
                    if (busy !== 1'b1) begin
                        mismatched++;
                        $display("[TB] FAIL long_busy_held got=%b exp=1", busy);
                    end
                end
                // Segment 2 falls on the very edge the long threshold is reached.
                if (s == 3 && i <= 1) begin
                    compared++;
                    if (busy !== (i == 0)) begin
                        mismatched++;
                        $display("[TB] FAIL long_edge_busy i=%0d got=%b exp=%b", i, busy, i == 0);
                    end
                end
            end
        end
    endtask

    task automatic test_double_click();
        logic [4:0] o, e;
        logic vals[6] = '{1, 0, 1, 0, 1, 0};
        int   lens[6] = '{5, 4, 5, 2, 3, 25};
        for (int s = 0; s < 6; s++) begin
            set_in(vals[s]);
            if (s == 3) push(cyc + 1, DOUBLE);
            if (s == 5) push(cyc + 1 + W, SHORT);
            for (int i = 0; i < lens[s]; i++) begin
                tick(o, e);
                compared++;
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL double_click seg=%0d cyc=%0d got=%b exp=%b", s, cyc, o, e);
                end
            end
        end
    endtask

    task automatic test_window_edge();
        logic [4:0] o, e;
        int lens[8] = '{5, 10, 3, 25, 5, 9, 3, 20};
        for (int s = 0; s < 8; s++) begin
            set_in(s % 2 == 0);
            if (s == 1 || s == 3 || s == 5 + 10) push(cyc + 1 + W, SHORT);
            if (s == 7) push(cyc + 1, DOUBLE);
            for (int i = 0; i < lens[s]; i++) begin
                tick(o, e);
                compared++;
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL window_edge seg=%0d cyc=%0d got=%b exp=%b", s, cyc, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press2();
        logic [4:0] o, e;
        int lens[3] = '{5, 4, 3};
        for (int s = 0; s < 3; s++) begin
            set_in(s != 1);
            for (int i = 0; i < lens[s]; i++) begin
                tick(o, e);
                compared++;
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL press2_setup cyc=%0d got=%b exp=%b", cyc, o, e);
                end
            end
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({press_pulse, release_pulse, short_press, long_press, double_click, busy} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL press2_async_reset got=%b exp=000000",
                     {press_pulse, release_pulse, short_press, long_press, double_click, busy});
        end
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            tick(o, e);
            compared++;
            if ({o, busy} !== 6'b0) begin
                mismatched++;
                $display("[TB] FAIL press2_reset_hold cyc=%0d got=%b exp=000000", cyc, {o, busy});
            end
        end
        // Input still high as reset releases: the first edge must see a fresh press.
        rst_n   = 1'b1;
        last_in = 1'b0;
        set_in(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL press2_post_reset cyc=%0d got=%b exp=%b", cyc, o, e);
            end
        end
        set_in(1'b0);
        push(cyc + 1 + W, SHORT);
        for (int i = 0; i < 25; i++) begin
            tick(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL press2_post_reset cyc=%0d got=%b exp=%b", cyc, o, e);
            end
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_double_click();
        test_window_edge();
        test_reset_mid_press2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
